spi_cmd: RTL and testbench

- SPI target front end between the Raspberry Pi SPI bus and the register/memory bus consumers, such as the control register block at 0E80F and the RAM bridge.
- Oversamples SCK, CS and PICO in the clk_i domain and assembles mode-0 bytes.
- Decodes a fixed command frame and emits one-cycle bus transactions: rw_n, 17-bit address, data and enable.
- For reads, captures the returned byte and shifts it out on POCI.

---
 rtl/spi_cmd_pkg.sv | 23 ++
 rtl/spi_byte_io.sv | 93 +++++++++
 rtl/spi_cmd.sv | 162 ++++++++++++++++
 tb/tb_spi_cmd.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared types and constants for the SPI command front end.
//   spi_cmd_state_t : frame decoder states
//   CMD_RW_N_BIT    : command byte bit carrying rw_n (1 = read)
//   CMD_A16_BIT     : command byte bit carrying address bit 16
//   ADDR_WIDTH      : bus address width
//   DATA_WIDTH      : bus data / SPI byte width
package spi_cmd_pkg;

  localparam int ADDR_WIDTH   = 17;
  localparam int DATA_WIDTH   = 8;
  localparam int CMD_RW_N_BIT = 7;
  localparam int CMD_A16_BIT  = 0;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR_HI,
    ADDR_LO,
    DATA,
    DONE
  } spi_cmd_state_t;

endpackage

// File: rtl/spi_byte_io.sv
// spi_byte_io: SPI mode-0 byte engine in the clk_i domain.
//   clk_i, reset_i       : system clock, async active-high reset
//   spi_sck_i/cs_ni/pico_i : raw asynchronous SPI pins
//   tx_load, tx_data     : parallel load of the transmit shift register
//   tx_bit               : current transmit bit (MSB of tx register)
//   rx_byte              : assembled receive byte, valid with byte_valid
//   byte_valid           : one-cycle pulse on the 8th rising SCK of a byte
//   cs_fall, cs_rise     : one-cycle chip-select edge pulses
module spi_byte_io
  import spi_cmd_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  spi_sck_i,
  input  logic                  spi_cs_ni,
  input  logic                  spi_pico_i,
  input  logic                  tx_load,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_bit,
  output logic [DATA_WIDTH-1:0] rx_byte,
  output logic                  byte_valid,
  output logic                  cs_fall,
  output logic                  cs_rise
);

  logic [1:0] sck_sync;
  logic [1:0] cs_sync;
  logic [1:0] pico_sync;
  logic       sck_prev;
  logic       cs_prev;
  logic       sck_rise;
  logic       sck_fall;
  logic       selected;
  logic [2:0] bit_cnt;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] tx_shift;

  // cs_n flops reset to 0 ("selected"): if reset drops while the Pi is
  // mid-frame no falling edge is seen, so the rest of that frame is ignored
  // until cs_n goes high and falls again.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sck_sync  <= 2'b00;
      cs_sync   <= 2'b00;
      pico_sync <= 2'b00;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], spi_sck_i};
      cs_sync   <= {cs_sync[0], spi_cs_ni};
      pico_sync <= {pico_sync[0], spi_pico_i};
      sck_prev  <= sck_sync[1];
      cs_prev   <= cs_sync[1];
    end
  end

  assign sck_rise   = sck_sync[1] & ~sck_prev;
  assign sck_fall   = ~sck_sync[1] & sck_prev;
  assign cs_fall    = ~cs_sync[1] & cs_prev;
  assign cs_rise    = cs_sync[1] & ~cs_prev;
  assign selected   = ~cs_sync[1];
  assign byte_valid = sck_rise & selected & (bit_cnt == 3'd7);
  assign rx_byte    = {rx_shift[DATA_WIDTH-2:0], pico_sync[1]};
  assign tx_bit     = tx_shift[DATA_WIDTH-1];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bit_cnt  <= 3'd0;
      rx_shift <= '0;
    end else if (!selected) begin
      bit_cnt  <= 3'd0;
    end else if (sck_rise) begin
      bit_cnt  <= bit_cnt + 3'd1;
      rx_shift <= {rx_shift[DATA_WIDTH-2:0], pico_sync[1]};
    end
  end

  // The falling edge that follows the last bit of a byte (bit_cnt == 0) does
  // not shift, so a byte loaded between bytes keeps its MSB on the line until
  // the next byte's first rising edge has sampled it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tx_shift <= '0;
    end else if (cs_fall) begin
      tx_shift <= '0;
    end else if (tx_load) begin
      tx_shift <= tx_data;
    end else if (sck_fall && selected && (bit_cnt != 3'd0)) begin
      tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/spi_cmd.sv
// spi_cmd: SPI target front end decoding 4-byte command frames into
// one-cycle bus transactions.
//   Frame: cmd (bit7 rw_n, bit0 A16), A15..8, A7..0, data/dummy.
//   clk_i, reset_i   : system clock (>= 8x SCK), async active-high reset
//   spi_sck_i, spi_cs_ni, spi_pico_i : SPI pins from the Pi
//   spi_poci_o       : serial read data to the Pi
//   spi_rw_no        : 1 = read, 0 = write
//   spi_addr_o       : 17-bit transaction address
//   spi_data_o       : write data
//   spi_enable_o     : one-cycle transaction strobe
//   spi_rd_data_i    : read data, sampled RD_LAT cycles after the strobe
// Parameter RD_LAT (1..3): strobe-to-read-data latency in clk_i cycles.
// Build option SPI_CMD_AUTOINC_EN: extra bytes in a frame repeat the access
// at the next address instead of being ignored.
module spi_cmd
  import spi_cmd_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  spi_sck_i,
  input  logic                  spi_cs_ni,
  input  logic                  spi_pico_i,
  output logic                  spi_poci_o,
  output logic                  spi_rw_no,
  output logic [ADDR_WIDTH-1:0] spi_addr_o,
  output logic [DATA_WIDTH-1:0] spi_data_o,
  output logic                  spi_enable_o,
  input  logic [DATA_WIDTH-1:0] spi_rd_data_i
);

  spi_cmd_state_t        state;
  logic                  rw_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] lo_addr;
  logic                  rd_pending;
  logic [1:0]            rd_cnt;
  logic                  tx_load;
  logic                  tx_bit;
  logic [DATA_WIDTH-1:0] rx_byte;
  logic                  byte_valid;
  logic                  cs_fall;
  logic                  cs_rise;

  spi_byte_io u_byte_io (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .spi_sck_i  (spi_sck_i),
    .spi_cs_ni  (spi_cs_ni),
    .spi_pico_i (spi_pico_i),
    .tx_load    (tx_load),
    .tx_data    (spi_rd_data_i),
    .tx_bit     (tx_bit),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .cs_fall    (cs_fall),
    .cs_rise    (cs_rise)
  );

  // Full address as it stands when the low address byte arrives.
  assign lo_addr = {addr_q[ADDR_WIDTH-1:8], rx_byte};

  // Read data is taken in the cycle the latency counter reaches zero; this
  // runs independently of the FSM so an aborted frame still completes it.
  assign tx_load = rd_pending && (rd_cnt == 2'd0);

  // poci only carries data during the data phase; elsewhere it idles low.
  assign spi_poci_o = tx_bit && (state == DATA);

  // addr_q always holds the address of the next access in the frame.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= IDLE;
      rw_q         <= 1'b1;
      addr_q       <= '0;
      spi_rw_no    <= 1'b1;
      spi_addr_o   <= '0;
      spi_data_o   <= '0;
      spi_enable_o <= 1'b0;
      rd_pending   <= 1'b0;
      rd_cnt       <= 2'd0;
    end else begin
      spi_enable_o <= 1'b0;
      if (rd_pending) begin
        if (rd_cnt == 2'd0) rd_pending <= 1'b0;
        else                rd_cnt     <= rd_cnt - 2'd1;
      end

      if (cs_rise) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) state <= CMD;
          end
          CMD: begin
            if (byte_valid) begin
              rw_q        <= rx_byte[CMD_RW_N_BIT];
              addr_q[16]  <= rx_byte[CMD_A16_BIT];
              state       <= ADDR_HI;
            end
          end
          ADDR_HI: begin
            if (byte_valid) begin
              addr_q[15:8] <= rx_byte;
              state        <= ADDR_LO;
            end
          end
          ADDR_LO: begin
            if (byte_valid) begin
              state <= DATA;
              if (rw_q) begin
                spi_enable_o <= 1'b1;
                spi_rw_no    <= 1'b1;
                spi_addr_o   <= lo_addr;
                addr_q       <= lo_addr + 17'd1;
                rd_pending   <= 1'b1;
                rd_cnt       <= 2'(RD_LAT);
              end else begin
                addr_q[7:0]  <= rx_byte;
              end
            end
          end
          DATA: begin
            if (byte_valid) begin
              if (rw_q) begin
`ifdef SPI_CMD_AUTOINC_EN
                spi_enable_o <= 1'b1;
                spi_rw_no    <= 1'b1;
                spi_addr_o   <= addr_q;
                addr_q       <= addr_q + 17'd1;
                rd_pending   <= 1'b1;
                rd_cnt       <= 2'(RD_LAT);
`else
                state        <= DONE;
`endif
              end else begin
                spi_enable_o <= 1'b1;
                spi_rw_no    <= 1'b0;
                spi_addr_o   <= addr_q;
                spi_data_o   <= rx_byte;
`ifdef SPI_CMD_AUTOINC_EN
                addr_q       <= addr_q + 17'd1;
`else
                state        <= DONE;
`endif
              end
            end
          end
          DONE: begin
            state <= DONE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd.sv
// tb_spi_cmd: self-checking bench for spi_cmd.
// Two instances share the SPI bus: one with RD_LAT=1, one with RD_LAT=3.
// Expected strobes are queued when a frame is driven and matched every
// clock against spi_enable_o; read data is returned by a small latency model.
module tb_spi_cmd;

  localparam int HALF = 4;

  typedef struct packed {
    logic        rw;
    logic [16:0] addr;
    logic [7:0]  data;
  } txn_t;

  typedef struct packed {
    logic [31:0] frame;
    logic        rw;
    logic [16:0] addr;
    logic [7:0]  data;
    logic [7:0]  rdValue;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic sck;
  logic cs_n;
  logic pico;

  logic       poci_w [2];
  logic       rw_w   [2];
  logic       en_w   [2];
  logic [16:0] addr_w [2];
  logic [7:0] data_w [2];
  logic [7:0] rdd_w  [2];

  logic [7:0] rd_value = 8'h00;
  logic       pipe1 = 1'b0;
  logic [2:0] pipe3 = 3'b000;

  txn_t expQ0[$];
  txn_t expQ1[$];
  int   strobes[2];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  // Read data is only valid in the single cycle RD_LAT after the strobe.
  always @(posedge clk) begin
    pipe1 <= en_w[0];
    pipe3 <= {pipe3[1:0], en_w[1]};
  end
  assign rdd_w[0] = pipe1    ? rd_value : 8'h00;
  assign rdd_w[1] = pipe3[2] ? rd_value : 8'h00;

  spi_cmd #(.RD_LAT(1)) dut1 (
    .clk_i(clk), .reset_i(reset), .spi_sck_i(sck), .spi_cs_ni(cs_n),
    .spi_pico_i(pico), .spi_poci_o(poci_w[0]), .spi_rw_no(rw_w[0]),
    .spi_addr_o(addr_w[0]), .spi_data_o(data_w[0]),
    .spi_enable_o(en_w[0]), .spi_rd_data_i(rdd_w[0])
  );

  spi_cmd #(.RD_LAT(3)) dut3 (
    .clk_i(clk), .reset_i(reset), .spi_sck_i(sck), .spi_cs_ni(cs_n),
    .spi_pico_i(pico), .spi_poci_o(poci_w[1]), .spi_rw_no(rw_w[1]),
    .spi_addr_o(addr_w[1]), .spi_data_o(data_w[1]),
    .spi_enable_o(en_w[1]), .spi_rd_data_i(rdd_w[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic rw, input logic [16:0] addr, input logic [7:0] data);
    txn_t t;
    t = '{rw: rw, addr: addr, data: data};
    expQ0.push_back(t);
    expQ1.push_back(t);
  endtask

  task automatic checkStrobe(input int d);
    txn_t t;
    int   qs;
    if (en_w[d]) begin
      strobes[d]++;
      qs = (d == 0) ? expQ0.size() : expQ1.size();
      if (qs == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected strobe dut%0d: got addr %0h, expected none",
                 d, addr_w[d]);
      end else begin
        t = (d == 0) ? expQ0.pop_front() : expQ1.pop_front();
        checkOutput($sformatf("strobe rw dut%0d", d), 32'(rw_w[d]), 32'(t.rw));
        checkOutput($sformatf("strobe addr dut%0d", d), 32'(addr_w[d]), 32'(t.addr));
        if (!t.rw)
          checkOutput($sformatf("strobe data dut%0d", d), 32'(data_w[d]), 32'(t.data));
      end
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) begin
      @(negedge clk);
      checkStrobe(0);
      checkStrobe(1);
    end
  endtask

  task automatic sendBit(input logic v, input logic abortNow,
                         inout logic [7:0] rA, inout logic [7:0] rB);
    pico = v;
    waitClk(HALF);
    rA = {rA[6:0], poci_w[0]};
    rB = {rB[6:0], poci_w[1]};
    sck = 1'b1;
    if (abortNow) cs_n = 1'b1;
    waitClk(HALF);
    sck = 1'b0;
  endtask

  // Drives one CS frame; abortByte raises cs_n with that byte's last rising
  // SCK. The poci bits seen during byte 3 are returned per instance.
  task automatic applyStimulus(input logic [39:0] frame, input int nbytes,
                               input int abortByte, input int tailWait,
                               output logic [7:0] misoA, output logic [7:0] misoB);
    logic [7:0] by;
    logic [7:0] rA;
    logic [7:0] rB;
    misoA = 8'h00;
    misoB = 8'h00;
    cs_n = 1'b0;
    waitClk(HALF);
    for (int b = 0; b < nbytes; b++) begin
      by = frame[39-8*b -: 8];
      rA = 8'h00;
      rB = 8'h00;
      for (int i = 7; i >= 0; i--)
        sendBit(by[i], (b == abortByte) && (i == 0), rA, rB);
      if (b == 3) begin
        misoA = rA;
        misoB = rB;
      end
    end
    if (!cs_n) begin
      waitClk(tailWait);
      cs_n = 1'b1;
    end
    waitClk(12);
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, " queue1"}, 32'(expQ0.size()), 32'd0);
    checkOutput({name, " queue3"}, 32'(expQ1.size()), 32'd0);
    checkOutput({name, " poci1"}, 32'(poci_w[0]), 32'd0);
    checkOutput({name, " poci3"}, 32'(poci_w[1]), 32'd0);
  endtask

  task automatic checkReset(input string name);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s poci dut%0d", name, d), 32'(poci_w[d]), 32'd0);
      checkOutput($sformatf("%s rw dut%0d", name, d), 32'(rw_w[d]), 32'd1);
      checkOutput($sformatf("%s addr dut%0d", name, d), 32'(addr_w[d]), 32'd0);
      checkOutput($sformatf("%s data dut%0d", name, d), 32'(data_w[d]), 32'd0);
      checkOutput($sformatf("%s en dut%0d", name, d), 32'(en_w[d]), 32'd0);
    end
  endtask

  initial begin
    vec_t       vecs[6];
    logic [7:0] mA;
    logic [7:0] mB;
    logic [7:0] rA;
    logic [7:0] rB;
    int         s0;
    int         s1;

    vecs[0] = '{32'h00E80F03, 1'b0, 17'h0E80F, 8'h03, 8'h00};
    vecs[1] = '{32'h81234500, 1'b1, 17'h12345, 8'h00, 8'hA5};
    vecs[2] = '{32'h0000105A, 1'b0, 17'h00010, 8'h5A, 8'h00};
    vecs[3] = '{32'h80ABCD00, 1'b1, 17'h0ABCD, 8'h00, 8'h3C};
    vecs[4] = '{32'h7E1234FF, 1'b0, 17'h01234, 8'hFF, 8'h00};
    vecs[5] = '{32'hFE000700, 1'b1, 17'h00007, 8'h00, 8'h81};
    strobes[0] = 0;
    strobes[1] = 0;

    reset = 1'b1;
    sck   = 1'b0;
    cs_n  = 1'b1;
    pico  = 1'b0;
    repeat (3) @(negedge clk);
    checkReset("reset");
    reset = 1'b0;
    waitClk(5);

    for (int v = 0; v < 6; v++) begin
      rd_value = vecs[v].rdValue;
      pushExp(vecs[v].rw, vecs[v].addr, vecs[v].data);
      s0 = strobes[0];
      s1 = strobes[1];
      applyStimulus({vecs[v].frame, 8'h00}, 4, -1, HALF, mA, mB);
      checkIdle($sformatf("vec%0d", v));
      checkOutput($sformatf("vec%0d count1", v), 32'(strobes[0] - s0), 32'd1);
      checkOutput($sformatf("vec%0d count3", v), 32'(strobes[1] - s1), 32'd1);
      checkOutput($sformatf("vec%0d hold addr", v), 32'(addr_w[1]), 32'(vecs[v].addr));
      checkOutput($sformatf("vec%0d hold rw", v), 32'(rw_w[0]), 32'(vecs[v].rw));
      if (vecs[v].rw) begin
        checkOutput($sformatf("vec%0d poci byte1", v), 32'(mA), 32'(vecs[v].rdValue));
        checkOutput($sformatf("vec%0d poci byte3", v), 32'(mB), 32'(vecs[v].rdValue));
      end else begin
        checkOutput($sformatf("vec%0d hold data", v), 32'(data_w[0]), 32'(vecs[v].data));
      end
    end

    // Partial frame: two bytes then deselect, followed by a good write.
    s0 = strobes[0];
    applyStimulus({8'h00, 8'hE8, 24'h0}, 2, -1, HALF, mA, mB);
    checkOutput("partial count", 32'(strobes[0] - s0), 32'd0);
    checkOutput("partial hold addr", 32'(addr_w[0]), 32'h00007);
    pushExp(1'b0, 17'h00010, 8'h5A);
    applyStimulus({32'h0000105A, 8'h00}, 4, -1, HALF, mA, mB);
    checkIdle("after partial");

    // Reset in the middle of byte 2 of a write.
    rA = 8'h00;
    rB = 8'h00;
    cs_n = 1'b0;
    waitClk(HALF);
    for (int i = 7; i >= 0; i--) sendBit(1'b0, 1'b0, rA, rB);
    for (int i = 7; i >= 0; i--) sendBit(rA[0] ^ 1'b1, 1'b0, rA, rB);
    for (int i = 7; i >= 4; i--) sendBit(1'b1, 1'b0, rA, rB);
    reset = 1'b1;
    #1;
    checkReset("midreset");
    waitClk(3);
    reset = 1'b0;
    s0 = strobes[0];
    s1 = strobes[1];
    for (int i = 3; i >= 0; i--) sendBit(1'b1, 1'b0, rA, rB);
    for (int i = 7; i >= 0; i--) sendBit(1'b1, 1'b0, rA, rB);
    waitClk(HALF);
    cs_n = 1'b1;
    waitClk(12);
    checkOutput("midreset count1", 32'(strobes[0] - s0), 32'd0);
    checkOutput("midreset count3", 32'(strobes[1] - s1), 32'd0);
    pushExp(1'b0, 17'h10007, 8'hC3);
    applyStimulus({32'h010007C3, 8'h00}, 4, -1, HALF, mA, mB);
    checkIdle("after reset");
    checkOutput("after reset data", 32'(data_w[1]), 32'h000000C3);

    // Five-byte frame across the top of the address space.
    pushExp(1'b0, 17'h1FFFF, 8'h11);
`ifdef SPI_CMD_AUTOINC_EN
    pushExp(1'b0, 17'h00000, 8'h22);
`endif
    applyStimulus({8'h01, 8'hFF, 8'hFF, 8'h11, 8'h22}, 5, -1, HALF, mA, mB);
    checkIdle("five byte");
`ifdef SPI_CMD_AUTOINC_EN
    checkOutput("five byte addr", 32'(addr_w[0]), 32'h00000);
    checkOutput("five byte data", 32'(data_w[0]), 32'h22);
`else
    checkOutput("five byte addr", 32'(addr_w[0]), 32'h1FFFF);
    checkOutput("five byte data", 32'(data_w[0]), 32'h11);
`endif

    // Deselect on the same cycle as the 4th byte_valid of a write.
    s0 = strobes[0];
    s1 = strobes[1];
    applyStimulus({32'h00123477, 8'h00}, 4, 3, HALF, mA, mB);
    checkOutput("abort count1", 32'(strobes[0] - s0), 32'd0);
    checkOutput("abort count3", 32'(strobes[1] - s1), 32'd0);

    // Read strobe issued, then deselect before the capture lands.
    rd_value = 8'h96;
    pushExp(1'b1, 17'h10001, 8'h00);
    applyStimulus({8'h81, 8'h00, 8'h01, 16'h0}, 3, -1, 0, mA, mB);
    checkIdle("read abort");
    checkOutput("read abort addr", 32'(addr_w[1]), 32'h10001);
    checkOutput("read abort rw", 32'(rw_w[1]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
